// File: rtl/ic_test_sequencer.sv
// ic_test_sequencer
// Run controller for an N-input gate checker. An operator start press enables
// the checker for a fixed number of cycles (RUN_CYCLES), then the checker's
// pass/fail pair is sampled once and turned into a single sticky verdict plus
// saturating pass/fail tallies. The run is timed rather than edge-watched
// because the checker's flags are sticky and lag one sweep.
//
// Ports:
//   clk, reset       system clock, asynchronous active-high reset
//   start, abort     operator buttons (asynchronous levels, synchronised here)
//   pass, fail       checker result flags (clk domain)
//   checker_enable   drives checker enable, high for RUN_CYCLES cycles per run
//   busy             run in progress (RUN/SAMPLE/REPORT)
//   done, aborted    one-cycle pulses at verdict latch / abort
//   verdict_*        sticky outcome of the last completed run
//   pass_count       passing runs, saturating at 255
//   fail_count       failing or invalid runs, saturating at 255
module ic_test_sequencer #(
    parameter int              STEP_CYCLES = 50000000,
    parameter int              STEPS       = 32,
    parameter int              SWEEPS      = 3,
    // 64-bit so the default product (~4.8e9) does not overflow int
    parameter longint unsigned RUN_CYCLES  = 64'(SWEEPS) * 64'(STEPS) * (64'(STEP_CYCLES) + 64'd1),
    parameter int              TW          = 40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       pass,
    input  logic       fail,
    output logic       checker_enable,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic       verdict_pass,
    output logic       verdict_fail,
    output logic       verdict_invalid,
    output logic [7:0] pass_count,
    output logic [7:0] fail_count
);

    localparam logic [TW-1:0] RUN_LAST = TW'(RUN_CYCLES - 64'd1);
    localparam logic [7:0]    CNT_MAX  = 8'hFF;

    typedef enum logic [1:0] {IDLE, RUN, SAMPLE, REPORT} state_t;

    state_t        state, nstate;
    logic [TW-1:0] timer;
    logic          start_s1, start_s2, start_s2_d, start_pulse;
    logic          abort_s1, abort_s2;
    logic          pass_r, fail_r;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nstate;
    end

    // Next-state logic; abort wins over timer expiry in RUN
    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (start_pulse && !abort_s2) nstate = RUN;
            RUN:     if (abort_s2)                 nstate = IDLE;
                     else if (timer == RUN_LAST)   nstate = SAMPLE;
            SAMPLE:  nstate = REPORT;
            REPORT:  nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // Outputs decoded from the state register, so they are glitch-free and
    // drop immediately when reset clears the state.
    always_comb begin
        checker_enable = (state == RUN);
        busy           = (state != IDLE);
    end

    // Synchronisers, run timer, verdicts, tallies and pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_s1        <= 1'b0;
            start_s2        <= 1'b0;
            start_s2_d      <= 1'b0;
            start_pulse     <= 1'b0;
            abort_s1        <= 1'b0;
            abort_s2        <= 1'b0;
            timer           <= '0;
            pass_r          <= 1'b0;
            fail_r          <= 1'b0;
            done            <= 1'b0;
            aborted         <= 1'b0;
            verdict_pass    <= 1'b0;
            verdict_fail    <= 1'b0;
            verdict_invalid <= 1'b0;
            pass_count      <= 8'd0;
            fail_count      <= 8'd0;
        end else begin
            start_s1    <= start;
            start_s2    <= start_s1;
            start_s2_d  <= start_s2;
            // registered rising-edge detect: one pulse per press
            start_pulse <= start_s2 & ~start_s2_d;
            abort_s1    <= abort;
            abort_s2    <= abort_s1;
            done        <= 1'b0;
            aborted     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_pulse && !abort_s2) begin
                        verdict_pass    <= 1'b0;
                        verdict_fail    <= 1'b0;
                        verdict_invalid <= 1'b0;
                        timer           <= '0;
                    end
                end
                RUN: begin
                    if (abort_s2) aborted <= 1'b1;
                    else          timer   <= timer + 1'b1;
                end
                SAMPLE: begin
                    pass_r <= pass;
                    fail_r <= fail;
                end
                REPORT: begin
                    done <= 1'b1;
                    if (pass_r && !fail_r) begin
                        verdict_pass <= 1'b1;
                        if (pass_count != CNT_MAX) pass_count <= pass_count + 8'd1;
                    end else begin
                        if (!pass_r && fail_r) verdict_fail    <= 1'b1;
                        else                   verdict_invalid <= 1'b1;
                        if (fail_count != CNT_MAX) fail_count <= fail_count + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ic_test_sequencer.sv
// Bench for ic_test_sequencer with RUN_CYCLES = 2*4*(3+1) = 32.
// A countdown model predicts every output each cycle; literal checks pin the
// model on the directed scenarios (run length, done lag, verdicts, abort,
// held start, async reset, count saturation).
module tb_ic_test_sequencer;

    localparam int SC = 3, ST = 4, SW = 2, RUNC = 32;

    logic       clk = 1'b0;
    logic       rst, start, abort, pass, fail;
    logic       checker_enable, busy, done, aborted;
    logic       verdict_pass, verdict_fail, verdict_invalid;
    logic [7:0] pass_count, fail_count;

    ic_test_sequencer #(
        .STEP_CYCLES(SC), .STEPS(ST), .SWEEPS(SW), .TW(16)
    ) dut (
        .clk(clk), .reset(rst), .start(start), .abort(abort),
        .pass(pass), .fail(fail),
        .checker_enable(checker_enable), .busy(busy), .done(done),
        .aborted(aborted), .verdict_pass(verdict_pass),
        .verdict_fail(verdict_fail), .verdict_invalid(verdict_invalid),
        .pass_count(pass_count), .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // ---------------- model ----------------
    // Raw input samples per edge: a start press becomes visible to the
    // sequencer three edges after it is sampled, abort two edges after.
    bit sh [4];
    bit ah [2];
    int en_left, tail;     // enable cycles remaining; post-run cycles remaining
    bit m_p, m_f, m_pulse, m_alvl;
    bit e_done, e_abt, e_vp, e_vf, e_vi;
    int e_pc, e_fc;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) sh[i] = 1'b0;
            ah[0] = 1'b0; ah[1] = 1'b0;
            en_left = 0; tail = 0; m_p = 0; m_f = 0;
            e_done = 0; e_abt = 0; e_vp = 0; e_vf = 0; e_vi = 0;
            e_pc = 0; e_fc = 0;
        end else begin
            m_pulse = sh[2] && !sh[3];
            m_alvl  = ah[1];
            e_done = 0; e_abt = 0;
            if (en_left > 0) begin
                if (m_alvl) begin
                    en_left = 0; e_abt = 1;
                end else begin
                    en_left--;
                    if (en_left == 0) tail = 2;
                end
            end else if (tail == 2) begin
                m_p = pass; m_f = fail; tail = 1;
            end else if (tail == 1) begin
                tail = 0; e_done = 1;
                if (m_p && !m_f) begin
                    e_vp = 1;
                    if (e_pc < 255) e_pc++;
                end else begin
                    if (!m_p && m_f) e_vf = 1;
                    else             e_vi = 1;
                    if (e_fc < 255) e_fc++;
                end
            end else if (m_pulse && !m_alvl) begin
                en_left = RUNC; e_vp = 0; e_vf = 0; e_vi = 0;
            end
            sh[3] = sh[2]; sh[2] = sh[1]; sh[1] = sh[0]; sh[0] = start;
            ah[1] = ah[0]; ah[0] = abort;
        end
    end

    // ---------------- compare + monitors ----------------
    int cyc = 0, en_cnt = 0, fall_cyc = 0, done_cyc = 0, done_n = 0, abort_n = 0;
    bit prev_en = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            chk("m_enable",  checker_enable,  32'(en_left > 0));
            chk("m_busy",    busy,            32'(en_left > 0 || tail > 0));
            chk("m_done",    done,            32'(e_done));
            chk("m_aborted", aborted,         32'(e_abt));
            chk("m_vpass",   verdict_pass,    32'(e_vp));
            chk("m_vfail",   verdict_fail,    32'(e_vf));
            chk("m_vinv",    verdict_invalid, 32'(e_vi));
            chk("m_pcount",  pass_count,      32'(e_pc));
            chk("m_fcount",  fail_count,      32'(e_fc));
        end
        if (checker_enable) en_cnt++;
        if (prev_en && !checker_enable) fall_cyc = cyc;
        prev_en = checker_enable;
        if (done) begin done_n++; done_cyc = cyc; end
        if (aborted) abort_n++;
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic press();
        start = 1'b1; tick(2); start = 1'b0;
    endtask

    task automatic run(input bit p, input bit f, input string nm);
        int base, k;
        pass = p; fail = f; en_cnt = 0;
        base = done_n + abort_n;
        press();
        k = 0;
        while (done_n + abort_n == base && k < 100) begin tick(1); k++; end
        chk({nm, "_ended"}, done_n + abort_n - base, 1);
        tick(2);
    endtask

    task automatic wait_en(input int n, input string nm);
        int k;
        k = 0;
        while (en_cnt < n && k < 100) begin tick(1); k++; end
        chk({nm, "_reached"}, en_cnt, n);
    endtask

    int dn0, ab0;

    initial begin
        rst = 1'b1; start = 0; abort = 0; pass = 0; fail = 0;
        tick(3);
        chk("rst_enable", checker_enable, 0);
        chk("rst_busy",   busy, 0);
        chk("rst_pc",     pass_count, 0);
        rst = 1'b0;
        tick(2);

        // passing run
        run(1, 0, "run_pass");
        chk("pass_en_cycles", en_cnt, 32);
        chk("pass_done_lag",  done_cyc - fall_cyc, 2);
        chk("pass_vpass",     verdict_pass, 1);
        chk("pass_pc",        pass_count, 1);
        chk("pass_busy",      busy, 0);

        run(0, 1, "run_fail");
        chk("fail_vfail", verdict_fail, 1);
        chk("fail_vpass", verdict_pass, 0);
        run(1, 1, "run_inv11");
        chk("inv11_vinv", verdict_invalid, 1);
        run(0, 0, "run_inv00");
        chk("inv00_vinv",  verdict_invalid, 1);
        chk("inv00_vfail", verdict_fail, 0);
        chk("inv_fc",      fail_count, 3);
        chk("inv_pc",      pass_count, 1);

        // abort at run cycle 10
        pass = 1; fail = 0; en_cnt = 0; dn0 = done_n; ab0 = abort_n;
        press();
        wait_en(10, "abort_wait");
        abort = 1'b1;
        tick(3);
        chk("abort_en_low", checker_enable, 0);
        abort = 1'b0;
        tick(5);
        chk("abort_pulses", abort_n - ab0, 1);
        chk("abort_nodone", done_n - dn0, 0);
        chk("abort_vpass",  verdict_pass, 0);
        chk("abort_vfail",  verdict_fail, 0);
        chk("abort_vinv",   verdict_invalid, 0);
        chk("abort_pc",     pass_count, 1);
        chk("abort_fc",     fail_count, 3);

        // start held high: one run only; then extra presses during a run
        dn0 = done_n;
        start = 1'b1; tick(100);
        chk("hold_one_run", done_n - dn0, 1);
        start = 1'b0; tick(3);
        press(); tick(8); press(); tick(8); press(); tick(80);
        chk("repress_runs", done_n - dn0, 2);
        chk("repress_pc",   pass_count, 3);

        // asynchronous reset at run cycle 20
        pass = 1; fail = 0; en_cnt = 0;
        press();
        wait_en(20, "rst_wait");
        @(posedge clk); #2;
        rst = 1'b1; #1;
        chk("arst_enable", checker_enable, 0);
        chk("arst_busy",   busy, 0);
        chk("arst_done",   done, 0);
        chk("arst_abt",    aborted, 0);
        chk("arst_vpass",  verdict_pass, 0);
        chk("arst_vfail",  verdict_fail, 0);
        chk("arst_vinv",   verdict_invalid, 0);
        chk("arst_pc",     pass_count, 0);
        chk("arst_fc",     fail_count, 0);
        tick(2);
        rst = 1'b0;
        tick(2);
        run(1, 0, "post_rst");
        chk("post_rst_en", en_cnt, 32);
        chk("post_rst_vp", verdict_pass, 1);
        chk("post_rst_pc", pass_count, 1);

        // saturation: 256 passing runs since reset
        for (int i = 0; i < 254; i++) run(1, 0, "sat");
        chk("sat_255", pass_count, 255);
        run(1, 0, "sat_extra");
        chk("sat_hold", pass_count, 255);
        chk("sat_fc",   fail_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
